note_detector: RTL

Measures the period of an incoming note square wave and identifies which C5–B5 note it is. It is the receiving end of the note tone path: a note generator toggles a square wave, and this block turns that wave back into a note code. Typical uses are feedback from the keyboard tone output and self-test of the note generators. It runs entirely in the system clock domain and synchronises the tone input internally.

---
 rtl/note_detector.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/note_detector.sv
// rtl/note_detector.sv - tone period meter and C5..B5 classifier; NOTE_DET_HOLD_EN requires two matching periods before the code changes
module note_detector #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TOL     = 256,
   parameter int TIMEOUT = 131071
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tone_in,
   output logic [2:0]  note_code,
   output logic        note_valid,
   output logic [17:0] period_out,
   output logic        new_period
);

   // Expected full periods of each note, in clk cycles, as a generator produces them.
   localparam int HALF = CLK_HZ / 2;
   localparam int P_C5 = 2 * (HALF / 523 + 1);
   localparam int P_D5 = 2 * (HALF / 587 + 1);
   localparam int P_E5 = 2 * (HALF / 659 + 1);
   localparam int P_F5 = 2 * (HALF / 698 + 1);
   localparam int P_G5 = 2 * (HALF / 784 + 1);
   localparam int P_A5 = 2 * (HALF / 880 + 1);
   localparam int P_B5 = 2 * (HALF / 988 + 1);

   localparam logic [17:0] TIMEOUT_CNT = 18'(TIMEOUT);

   typedef enum logic {
      IDLE,
      MEASURE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        s1;
   logic        s2;
   logic        s3;
   logic        rise;
   logic [17:0] cnt;
   logic [17:0] cnt_next;
   int          cnt_i;
   logic [2:0]  cls_code;
   logic [2:0]  code_next;
   logic        valid_next;
   logic [17:0] period_next;
   logic        new_next;
`ifdef NOTE_DET_HOLD_EN
   logic [2:0]  cand;
   logic [2:0]  cand_next;
`endif

   function automatic logic in_window(input int c, input int p);
      return (c >= p - TOL) && (c <= p + TOL);
   endfunction

   assign rise  = s2 & ~s3;
   assign cnt_i = {14'd0, cnt};

   // Three-flop synchroniser; the third flop only serves edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= tone_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Map the running count onto a note; windows never overlap for sane TOL.
   always_comb begin
      cls_code = 3'd0;
      if (in_window(cnt_i, P_C5))      cls_code = 3'd1;
      else if (in_window(cnt_i, P_D5)) cls_code = 3'd2;
      else if (in_window(cnt_i, P_E5)) cls_code = 3'd3;
      else if (in_window(cnt_i, P_F5)) cls_code = 3'd4;
      else if (in_window(cnt_i, P_G5)) cls_code = 3'd5;
      else if (in_window(cnt_i, P_A5)) cls_code = 3'd6;
      else if (in_window(cnt_i, P_B5)) cls_code = 3'd7;
   end

   // Next-state logic: period counting, reporting on each rise, silence timeout.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      code_next   = note_code;
      valid_next  = note_valid;
      period_next = period_out;
      new_next    = 1'b0;
`ifdef NOTE_DET_HOLD_EN
      cand_next   = cand;
`endif
      case (state)
         IDLE: begin
            if (rise) begin
               cnt_next   = 18'd1;
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_next = cnt;
               new_next    = 1'b1;
               cnt_next    = 18'd1;
`ifdef NOTE_DET_HOLD_EN
               if (cls_code == cand) begin
                  code_next  = cls_code;
                  valid_next = (cls_code != 3'd0);
               end
               cand_next = cls_code;
`else
               code_next  = cls_code;
               valid_next = (cls_code != 3'd0);
`endif
            end else if (cnt == TIMEOUT_CNT) begin
               state_next = IDLE;
               code_next  = 3'd0;
               valid_next = 1'b0;
`ifdef NOTE_DET_HOLD_EN
               cand_next  = 3'd0;
`endif
            end else begin
               cnt_next = cnt + 18'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 18'd0;
         note_code  <= 3'd0;
         note_valid <= 1'b0;
         period_out <= 18'd0;
         new_period <= 1'b0;
`ifdef NOTE_DET_HOLD_EN
         cand       <= 3'd0;
`endif
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         note_code  <= code_next;
         note_valid <= valid_next;
         period_out <= period_next;
         new_period <= new_next;
`ifdef NOTE_DET_HOLD_EN
         cand       <= cand_next;
`endif
      end
   end

endmodule
